// File: rtl/fine_timing_sync_pkg.sv
// Shared constants for the fine timing stage: sample width, sign-quantised
// long-training reference, output field widths and FSM state encodings.
// No logic; imported by the interface, the correlator and the top level.
package fine_timing_sync_pkg;

    localparam int FIXED_POINT_WIDTH = 13;

    // Sign-only long-training reference; bit k describes r[k], 1 means -1.
    localparam int                    LTS_TAPS   = 16;
    localparam logic [LTS_TAPS-1:0]   LTS_REF_RE = 16'b1011_0010_0110_1100;
    localparam logic [LTS_TAPS-1:0]   LTS_REF_IM = 16'b0110_1001_1100_0101;

    localparam int IDX_W    = 8;
    localparam int PEAK_W   = 19;
    localparam int COARSE_W = 5;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SKIP   = 2'd1;
    localparam logic [1:0] ST_SEARCH = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Per-component accumulator width: sample bits + tree growth + one for the I/Q pair sum.
    function automatic int acc_width(input int taps);
        return FIXED_POINT_WIDTH + $clog2(taps) + 1;
    endfunction

endpackage

// File: rtl/fine_timing_sync_if.sv
// Sample stream, arm/restart controls and timing result of the fine timing stage.
// Pure wiring, no latency.
// No backpressure: samples are qualified by valid only.
interface fine_timing_sync_if;
    import fine_timing_sync_pkg::*;

    logic                                valid;
    logic signed [FIXED_POINT_WIDTH-1:0] signal_real;
    logic signed [FIXED_POINT_WIDTH-1:0] signal_imag;
    logic                                coarse_done;
    logic [COARSE_W-1:0]                 coarse_num;
    logic                                restart;
    logic [IDX_W-1:0]                    fine_idx;
    logic [PEAK_W-1:0]                   fine_peak;
    logic [COARSE_W-1:0]                 fine_coarse;
    logic                                fine_done;
    logic                                busy;

    modport master (
        output valid, signal_real, signal_imag, coarse_done, coarse_num, restart,
        input  fine_idx, fine_peak, fine_coarse, fine_done, busy
    );

    modport slave (
        input  valid, signal_real, signal_imag, coarse_done, coarse_num, restart,
        output fine_idx, fine_peak, fine_coarse, fine_done, busy
    );

endinterface

// File: rtl/fine_timing_sync_corr.sv
// Sign-only cross-correlator: delay line of past samples plus add/sub tree, |re|+|im| out.
// mag is combinational on the current input sample (the newest tap); delay line is registered.
// No backpressure: the delay line shifts on every valid sample and otherwise holds.
module fine_timing_sync_corr
    import fine_timing_sync_pkg::*;
#(
    parameter int                TAPS   = LTS_TAPS,
    parameter int                ACC_W  = acc_width(LTS_TAPS),
    parameter logic [TAPS-1:0]   REF_RE = LTS_REF_RE,
    parameter logic [TAPS-1:0]   REF_IM = LTS_REF_IM
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                valid,
    input  logic signed [FIXED_POINT_WIDTH-1:0] in_re,
    input  logic signed [FIXED_POINT_WIDTH-1:0] in_im,
    output logic [ACC_W:0]                      mag
);

    // tap_*_q[0] is the previous valid sample; the current input completes the window.
    logic signed [FIXED_POINT_WIDTH-1:0] tap_re_q [TAPS-1];
    logic signed [FIXED_POINT_WIDTH-1:0] tap_im_q [TAPS-1];
    logic signed [FIXED_POINT_WIDTH-1:0] tap_re_d [TAPS-1];
    logic signed [FIXED_POINT_WIDTH-1:0] tap_im_d [TAPS-1];

    logic signed [ACC_W-1:0] x_re [TAPS];
    logic signed [ACC_W-1:0] x_im [TAPS];
    logic signed [ACC_W-1:0] acc_re;
    logic signed [ACC_W-1:0] acc_im;
    logic        [ACC_W-1:0] abs_re;
    logic        [ACC_W-1:0] abs_im;

    // Shift the delay line on each valid sample, in every FSM state.
    always_comb begin
        tap_re_d = tap_re_q;
        tap_im_d = tap_im_q;
        if (valid) begin
            tap_re_d[0] = in_re;
            tap_im_d[0] = in_im;
            for (int j = 1; j < TAPS - 1; j++) begin
                tap_re_d[j] = tap_re_q[j-1];
                tap_im_d[j] = tap_im_q[j-1];
            end
        end
    end

    // Delay-line registers; cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < TAPS - 1; j++) begin
                tap_re_q[j] <= '0;
                tap_im_q[j] <= '0;
            end
        end else begin
            tap_re_q <= tap_re_d;
            tap_im_q <= tap_im_d;
        end
    end

    // x[0] newest ... x[TAPS-1] oldest; x[TAPS-1-k] meets conj(r[k]) with sign flips only.
    always_comb begin
        x_re[0] = ACC_W'(in_re);
        x_im[0] = ACC_W'(in_im);
        for (int j = 1; j < TAPS; j++) begin
            x_re[j] = ACC_W'(tap_re_q[j-1]);
            x_im[j] = ACC_W'(tap_im_q[j-1]);
        end
        acc_re = '0;
        acc_im = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc_re = acc_re + (REF_RE[k] ? -x_re[TAPS-1-k] : x_re[TAPS-1-k])
                            + (REF_IM[k] ? -x_im[TAPS-1-k] : x_im[TAPS-1-k]);
            acc_im = acc_im + (REF_RE[k] ? -x_im[TAPS-1-k] : x_im[TAPS-1-k])
                            - (REF_IM[k] ? -x_re[TAPS-1-k] : x_re[TAPS-1-k]);
        end
        // Unsigned magnitudes, so the most negative accumulator value maps correctly.
        abs_re = acc_re[ACC_W-1] ? ACC_W'(-acc_re) : ACC_W'(acc_re);
        abs_im = acc_im[ACC_W-1] ? ACC_W'(-acc_im) : ACC_W'(acc_im);
        mag    = (ACC_W+1)'(abs_re) + (ACC_W+1)'(abs_im);
    end

endmodule

// File: rtl/fine_timing_sync.sv
// Fine timing search: after a coarse arm, skips SKIP samples then finds the correlation peak in a window.
// Result registers and fine_done appear the cycle after the last window sample is accepted.
// No backpressure: progress is paced by valid; restart aborts to IDLE without a result.
module fine_timing_sync
    import fine_timing_sync_pkg::*;
#(
    parameter int TAPS       = LTS_TAPS,
    parameter int SKIP       = 32,
    parameter int SEARCH_LEN = 64
) (
    input  logic                clk,
    input  logic                rst,
    fine_timing_sync_if.slave   bus
);

    localparam int               ACC_W     = acc_width(TAPS);
    localparam int               MAG_W     = ACC_W + 1;
    localparam logic [IDX_W-1:0] SKIP_LAST = IDX_W'(SKIP - 1);
    localparam logic [IDX_W-1:0] WIN_LAST  = IDX_W'(SEARCH_LEN - 1);

    logic [MAG_W-1:0]    mag;
    logic [1:0]          state_q,       state_d;
    logic [IDX_W-1:0]    cnt_q,         cnt_d;
    logic [COARSE_W-1:0] coarse_q,      coarse_d;
    logic [MAG_W-1:0]    best_mag_q,    best_mag_d;
    logic [IDX_W-1:0]    best_idx_q,    best_idx_d;
    logic [IDX_W-1:0]    fine_idx_q,    fine_idx_d;
    logic [PEAK_W-1:0]   fine_peak_q,   fine_peak_d;
    logic [COARSE_W-1:0] fine_coarse_q, fine_coarse_d;
    logic                fine_done_q,   fine_done_d;

    fine_timing_sync_corr #(
        .TAPS   (TAPS),
        .ACC_W  (ACC_W),
        .REF_RE (LTS_REF_RE[TAPS-1:0]),
        .REF_IM (LTS_REF_IM[TAPS-1:0])
    ) u_corr (
        .clk   (clk),
        .rst   (rst),
        .valid (bus.valid),
        .in_re (bus.signal_real),
        .in_im (bus.signal_imag),
        .mag   (mag)
    );

    // FSM, sample counting and strict-greater peak tracking; restart overrides everything.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        coarse_d      = coarse_q;
        best_mag_d    = best_mag_q;
        best_idx_d    = best_idx_q;
        fine_idx_d    = fine_idx_q;
        fine_peak_d   = fine_peak_q;
        fine_coarse_d = fine_coarse_q;
        fine_done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.coarse_done) begin
                    state_d  = ST_SKIP;
                    cnt_d    = '0;
                    coarse_d = bus.coarse_num;
                end
            end
            ST_SKIP: begin
                if (bus.valid) begin
                    if (cnt_q == SKIP_LAST) begin
                        state_d    = ST_SEARCH;
                        cnt_d      = '0;
                        best_mag_d = '0;
                        best_idx_d = '0;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_SEARCH: begin
                if (bus.valid) begin
                    if (mag > best_mag_q) begin
                        best_mag_d = mag;
                        best_idx_d = cnt_q;
                    end
                    // The last window sample's own comparison is folded into the result.
                    if (cnt_q == WIN_LAST) begin
                        state_d       = ST_DONE;
                        fine_done_d   = 1'b1;
                        fine_idx_d    = best_idx_d;
                        fine_peak_d   = PEAK_W'(best_mag_d);
                        fine_coarse_d = coarse_q;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (bus.restart) begin
            state_d       = ST_IDLE;
            fine_done_d   = 1'b0;
            fine_idx_d    = fine_idx_q;
            fine_peak_d   = fine_peak_q;
            fine_coarse_d = fine_coarse_q;
        end
    end

    // State and result registers; reset drops any search in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            coarse_q      <= '0;
            best_mag_q    <= '0;
            best_idx_q    <= '0;
            fine_idx_q    <= '0;
            fine_peak_q   <= '0;
            fine_coarse_q <= '0;
            fine_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            coarse_q      <= coarse_d;
            best_mag_q    <= best_mag_d;
            best_idx_q    <= best_idx_d;
            fine_idx_q    <= fine_idx_d;
            fine_peak_q   <= fine_peak_d;
            fine_coarse_q <= fine_coarse_d;
            fine_done_q   <= fine_done_d;
        end
    end

    assign bus.fine_idx    = fine_idx_q;
    assign bus.fine_peak   = fine_peak_q;
    assign bus.fine_coarse = fine_coarse_q;
    assign bus.fine_done   = fine_done_q;
    assign bus.busy        = (state_q == ST_SKIP) || (state_q == ST_SEARCH);

endmodule
